fir_coeff_loader: RTL

Writer side of the FIR filter's coefficient interface. Accepts a framed stream of signed coefficient words over a valid/ready handshake and assembles them in a shadow bank. On a complete, well-formed frame it swaps the whole set atomically into the active bank that drives the filter's coefficient inputs. The filter never sees a partially loaded set; a malformed frame leaves the active set unchanged.

---
 rtl/fir_coeff_loader.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fir_coeff_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fir_coeff_loader
//  Description : Writer side of the FIR coefficient interface. Collects a
//                framed stream of signed coefficient words into a shadow
//                bank and copies the whole set into the active bank in one
//                cycle once the frame is complete and well formed.
//                Optional feature macro: COEFF_LOADER_CHECKSUM_EN. When it is
//                defined, a trailing checksum word (the sum of all taps,
//                modulo 2^COEFF_WIDTH) must match before the set is committed.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_coeff_loader #(
  parameter int N_TAPS      = 32,
  parameter int COEFF_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [COEFF_WIDTH-1:0]        in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [N_TAPS*COEFF_WIDTH-1:0] coeffs,
  output logic                          coeffs_valid,
  output logic                          swap,
  output logic                          busy,
  output logic                          frame_err
);

  // The counter has to reach N_TAPS (the checksum word index when enabled).
  localparam int c_CNT_W = $clog2(N_TAPS + 1);
`ifdef COEFF_LOADER_CHECKSUM_EN
  localparam logic [c_CNT_W-1:0] c_CSUM_IDX = c_CNT_W'(N_TAPS);
`else
  localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(N_TAPS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COMMIT = 3'd2,
    S_DRAIN  = 3'd3
`ifdef COEFF_LOADER_CHECKSUM_EN
    ,
    S_CHECK  = 3'd4
`endif
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [c_CNT_W-1:0]     r_count;
  logic [c_CNT_W-1:0]     w_cnt_next;
  logic                   r_ready_en;
  logic                   r_swap;
  logic                   r_frame_err;
  logic                   r_coeffs_valid;
  logic [COEFF_WIDTH-1:0] r_shadow [N_TAPS];
  logic [COEFF_WIDTH-1:0] r_active [N_TAPS];
  logic                   w_xfer;
  logic                   w_store;
  logic                   w_reject;
  logic                   w_commit;
`ifdef COEFF_LOADER_CHECKSUM_EN
  logic [COEFF_WIDTH-1:0] r_acc;
  logic [COEFF_WIDTH-1:0] r_csum_rx;
  logic                   w_csum_cap;
`endif

  // The loader only accepts words in the states that consume the stream;
  // r_ready_en keeps in_ready low through the reset cycle.
  assign in_ready = r_ready_en &&
                    ((r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DRAIN));
  assign w_xfer   = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_count;
    w_store      = 1'b0;
    w_reject     = 1'b0;
    w_commit     = 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
    w_csum_cap   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_store = 1'b1;
          if (in_last) begin
            // A one-word frame can never be complete.
            w_reject   = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_cnt_next   = c_CNT_W'(1);
            w_next_state = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
`ifdef COEFF_LOADER_CHECKSUM_EN
          if (r_count == c_CSUM_IDX) begin
            w_cnt_next = '0;
            if (in_last) begin
              w_csum_cap   = 1'b1;
              w_next_state = S_CHECK;
            end else begin
              w_reject     = 1'b1;
              w_next_state = S_DRAIN;
            end
          end else begin
            w_store    = 1'b1;
            w_cnt_next = r_count + c_CNT_W'(1);
            if (in_last) begin
              w_reject     = 1'b1;
              w_cnt_next   = '0;
              w_next_state = S_IDLE;
            end
          end
`else
          w_store    = 1'b1;
          w_cnt_next = r_count + c_CNT_W'(1);
          if (r_count == c_LAST_IDX) begin
            if (in_last) begin
              w_next_state = S_COMMIT;
            end else begin
              w_reject     = 1'b1;
              w_cnt_next   = '0;
              w_next_state = S_DRAIN;
            end
          end else if (in_last) begin
            w_reject     = 1'b1;
            w_cnt_next   = '0;
            w_next_state = S_IDLE;
          end
`endif
        end
      end
`ifdef COEFF_LOADER_CHECKSUM_EN
      S_CHECK: begin
        w_cnt_next = '0;
        if (r_acc == r_csum_rx) begin
          w_next_state = S_COMMIT;
        end else begin
          w_reject     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
`endif
      S_COMMIT: begin
        w_commit     = 1'b1;
        w_cnt_next   = '0;
        w_next_state = S_IDLE;
      end
      S_DRAIN: begin
        // Overlong frame: swallow words up to and including the last one.
        if (w_xfer && in_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: word counter, shadow/active banks and registered pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready_en     <= 1'b0;
      r_count        <= '0;
      r_swap         <= 1'b0;
      r_frame_err    <= 1'b0;
      r_coeffs_valid <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_ready_en  <= 1'b1;
      r_count     <= w_cnt_next;
      r_swap      <= w_commit;
      r_frame_err <= w_reject;
      for (int i = 0; i < N_TAPS; i++) begin
        if (w_store && (r_count == c_CNT_W'(i))) begin
          r_shadow[i] <= in_data;
        end
      end
      // Whole-bank copy in one edge so the filter never sees a mixed set.
      if (w_commit) begin
        for (int i = 0; i < N_TAPS; i++) begin
          r_active[i] <= r_shadow[i];
        end
        r_coeffs_valid <= 1'b1;
      end
    end
  end

`ifdef COEFF_LOADER_CHECKSUM_EN
  // Running checksum restarts on the first word of each frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_csum_rx <= '0;
    end else begin
      if (w_store) begin
        r_acc <= ((r_count == '0) ? '0 : r_acc) + in_data;
      end
      if (w_csum_cap) begin
        r_csum_rx <= in_data;
      end
    end
  end
`endif

  generate
    for (genvar g = 0; g < N_TAPS; g++) begin : g_pack
      assign coeffs[g*COEFF_WIDTH +: COEFF_WIDTH] = r_active[g];
    end
  endgenerate

`ifdef COEFF_LOADER_CHECKSUM_EN
  assign busy = (r_state == S_LOAD) || (r_state == S_CHECK) || (r_state == S_COMMIT);
`else
  assign busy = (r_state == S_LOAD) || (r_state == S_COMMIT);
`endif

  assign swap         = r_swap;
  assign frame_err    = r_frame_err;
  assign coeffs_valid = r_coeffs_valid;

endmodule
`default_nettype wire
